cabac_mvd_neigh_buf: RTL and testbench
======================================

Name: cabac_mvd_neigh_buf

Overview:
Parametrised successor to the fixed 18x4 left-neighbour MVD store used by CABAC context modelling. It holds per-entry, per-list MVD pairs (x,y) for NUM_CH reference lists and supports masked per-list writes. Reads are registered with write-first bypass. Per-channel valid bits give a one-cycle invalidate at CTU/row boundaries, and unwritten neighbours read as zero. It sits between the CABAC syntax-element binariser (writer) and the mvd context-increment logic (reader).

Parameters:
ADDR_W, 2, address width
DEPTH, 4, number of entries (DEPTH <= 2**ADDR_W)
COMP_W, 9, width of one MVD component (FMV_WIDTH+1), two's complement
NUM_CH, 2, number of reference-list channels
(derived) CH_W = 2*COMP_W; DATA_W = NUM_CH*CH_W; channel c occupies bits [c*CH_W +: CH_W], with {y,x} inside and x in the LSBs.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr_i  in  1  invalidate all entries and channels
r_en  in  1  read request
r_addr  in  ADDR_W  read address
r_data  out  DATA_W  read data, registered
r_vld  out  1  r_data updated this cycle
w_en  in  1  write request
w_mask  in  NUM_CH  per-channel write enable
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Polarity and synchronicity are fixed.
- Reset: all valid bits = 0, r_data = 0, r_vld = 0. The storage array is not reset. rst overrides every other input in the same cycle.
- Write (cycle t): for each c with w_en & w_mask[c] & (w_addr < DEPTH), store channel c field and set valid[w_addr][c] at the end of t. Unmasked channels are unchanged.
- Read: r_en at cycle t gives r_data/r_vld at t+1. Latency is 1 cycle. r_vld is a single-cycle pulse per read. When r_en = 0, r_data holds its last value and r_vld = 0.
- Per channel, the read value is:
  - the write data, if the same-cycle write hits the same address with that channel masked (write-first bypass);
  - otherwise the stored field, if its valid bit is 1;
  - otherwise 0.
- r_addr >= DEPTH: r_data = 0, r_vld = 1. w_addr >= DEPTH: the write is ignored.
- clr_i in cycle t clears all valid bits at the end of t.
  - A same-cycle read sees the pre-clear state, including bypass.
  - A same-cycle write is applied after the clear, so the written channels end valid and all others end invalid.
- Back-to-back reads and writes are allowed every cycle. No stalls and no backpressure.
- No arithmetic except the optional feature. All fields are passed through bit-exact.

Optional Feature:
CABAC_MVD_ABS_SAT_EN
- Defined: each COMP_W field is converted at write time to |v|, saturated to 2**(COMP_W-1)-1. The most negative value saturates to that same maximum. The result is stored unsigned with MSB 0. The bypass path returns the converted value too.
- Undefined: fields are stored and returned verbatim.

Decomposition:
- Package cabac_mvd_pkg holds:
  - COMP_W default derived from FMV_WIDTH;
  - localparams CH_W and DATA_W;
  - mvd_comp_t and mvd_pair_t types;
  - an abs_sat function, used only under the macro.
- One sub-module, cabac_mvd_neigh_ch, is natural: a single-channel slice containing storage, valid bits, bypass and zero-fill. It is instantiated NUM_CH times by the top, which owns r_vld and address-range checks.

Test Plan:
- Reset, then read addr 0..3 on ch0/ch1 without writing -> r_data = 0, r_vld pulses at t+1 each read.
- Write addr 2, mask 2'b01, ch0 = {y=-3, x=5}; read addr 2 next cycle -> ch0 = {9'h1FD, 9'h005}, ch1 = 0.
- Same-cycle write and read, addr 1, mask 2'b11, data {ch1={7,-1}, ch0={0,2}} -> r_data at t+1 equals the written data (bypass).
- Fill all entries, assert clr_i with a simultaneous write to addr 3 ch1 = {1,1} -> subsequent reads return 0 everywhere except addr 3 ch1 = {1,1}.
- Assert rst mid-stream with r_en = 1 -> next cycle r_vld = 0, r_data = 0, all entries read 0 afterwards.
- With CABAC_MVD_ABS_SAT_EN, write x = 9'h100 (-256) and y = -7 -> read returns x = 255, y = 7. Without the macro the same write returns 9'h100 and 9'h1F9.

Source files
------------

// File: rtl/cabac_mvd_pkg.sv
// ---------------------------------------------------------------------------
// cabac_mvd_pkg
// Shared constants, types and helpers for the CABAC left-neighbour MVD store.
//   FMV_WIDTH   : fractional motion-vector width; one MVD component is one bit wider
//   MVD_COMP_W  : default width of one MVD component (two's complement)
//   MVD_NUM_CH  : default number of reference-list channels
//   MVD_CH_W    : bits per channel ({y,x}, x in the LSBs)
//   MVD_DATA_W  : bits per entry across all channels
//   abs_sat()   : magnitude with saturation, used only when CABAC_MVD_ABS_SAT_EN
//                 is defined
// ---------------------------------------------------------------------------
package cabac_mvd_pkg;

    localparam int FMV_WIDTH  = 8;
    localparam int MVD_COMP_W = FMV_WIDTH + 1;
    localparam int MVD_NUM_CH = 2;
    localparam int MVD_CH_W   = 2 * MVD_COMP_W;
    localparam int MVD_DATA_W = MVD_NUM_CH * MVD_CH_W;

    typedef logic signed [MVD_COMP_W-1:0] mvd_comp_t;

    typedef struct packed {
        mvd_comp_t y;
        mvd_comp_t x;
    } mvd_pair_t;

    // |v| clipped to 2**(w-1)-1. The input is a sign-extended w-bit value so
    // the function serves any component width; the most negative input maps
    // to the same maximum as every other overflowing magnitude.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v,
                                            input int unsigned w);
        logic [31:0] max_v;
        logic [31:0] mag;
        max_v = (32'd1 << (w - 1)) - 32'd1;
        mag   = v[31] ? 32'(-v) : 32'(v);
        return (mag > max_v) ? max_v : mag;
    endfunction

endpackage

// File: rtl/cabac_mvd_neigh_ch.sv
// ---------------------------------------------------------------------------
// cabac_mvd_neigh_ch
// One reference-list channel of the MVD neighbour store: storage array, valid
// bits, write-first bypass and zero-fill for never-written entries.
// Optional macro: CABAC_MVD_ABS_SAT_EN converts each component to a saturated
// magnitude at write time (the bypass path returns the converted value too).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears valid and r_data)
//   clr_i     : invalidate every entry at the end of this cycle
//   r_en      : read request; r_data updates on the next edge
//   r_zero    : read address is out of range, return zero
//   r_addr    : read address
//   w_en      : write request for this channel, already range-checked and masked
//   w_addr    : write address
//   w_data    : {y,x} for this channel
//   r_data    : registered read data
// ---------------------------------------------------------------------------
module cabac_mvd_neigh_ch
    import cabac_mvd_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4,
    parameter int COMP_W = MVD_COMP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  r_en,
    input  logic                  r_zero,
    input  logic [ADDR_W-1:0]     r_addr,
    input  logic                  w_en,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [2*COMP_W-1:0]   w_data,
    output logic [2*COMP_W-1:0]   r_data
);

    logic [2*COMP_W-1:0] w_conv;
    logic [2*COMP_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]    valid_reg;
    logic [2*COMP_W-1:0] r_data_reg;
    logic                bypass;

    // Per-component write conversion (x then y).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
`ifdef CABAC_MVD_ABS_SAT_EN
            assign w_conv[gi*COMP_W +: COMP_W] =
                COMP_W'(abs_sat(32'(signed'(w_data[gi*COMP_W +: COMP_W])), COMP_W));
`else
            assign w_conv[gi*COMP_W +: COMP_W] = w_data[gi*COMP_W +: COMP_W];
`endif
        end
    endgenerate

    assign bypass = w_en && (w_addr == r_addr);

    // Storage is deliberately not reset so it maps onto block RAM; the valid
    // bits alone decide whether stored contents are visible.
    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            mem[w_addr] <= w_conv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= '0;
            r_data_reg <= '0;
        end else begin
            // Read uses pre-edge valid bits, so a same-cycle clear is not seen.
            if (r_en) begin
                if (r_zero) begin
                    r_data_reg <= '0;
                end else if (bypass) begin
                    r_data_reg <= w_conv;
                end else if (valid_reg[r_addr]) begin
                    r_data_reg <= mem[r_addr];
                end else begin
                    r_data_reg <= '0;
                end
            end
            // Clear first, then the write: a same-cycle write survives the clear.
            if (clr_i) begin
                valid_reg <= '0;
            end
            if (w_en) begin
                valid_reg[w_addr] <= 1'b1;
            end
        end
    end

    assign r_data = r_data_reg;

endmodule

// File: rtl/cabac_mvd_neigh_buf.sv
// ---------------------------------------------------------------------------
// cabac_mvd_neigh_buf
// Left-neighbour MVD store for CABAC context modelling: DEPTH entries, each
// holding an {y,x} MVD pair for NUM_CH reference lists, masked per-list
// writes, registered reads with write-first bypass, one-cycle invalidate.
// Optional macro: CABAC_MVD_ABS_SAT_EN stores saturated magnitudes instead of
// the raw two's-complement components.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : invalidate all entries and channels (end of cycle)
//   r_en     : read request, r_addr : read address
//   r_data   : read data, registered (channel c at [c*CH_W +: CH_W])
//   r_vld    : one-cycle pulse, r_data updated this cycle
//   w_en     : write request, w_mask : per-channel write enable
//   w_addr   : write address, w_data : write data
// ---------------------------------------------------------------------------
module cabac_mvd_neigh_buf
    import cabac_mvd_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4,
    parameter int COMP_W = MVD_COMP_W,
    parameter int NUM_CH = MVD_NUM_CH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         r_en,
    input  logic [ADDR_W-1:0]            r_addr,
    output logic [NUM_CH*2*COMP_W-1:0]   r_data,
    output logic                         r_vld,
    input  logic                         w_en,
    input  logic [NUM_CH-1:0]            w_mask,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [NUM_CH*2*COMP_W-1:0]   w_data
);

    localparam int CH_W = 2 * COMP_W;

    logic r_oob;
    logic w_ok;
    logic r_vld_reg;

    // Out-of-range reads return zero; out-of-range writes are dropped.
    assign r_oob = (32'(r_addr) >= DEPTH);
    assign w_ok  = w_en && (32'(w_addr) < DEPTH);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            cabac_mvd_neigh_ch #(
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .COMP_W (COMP_W)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .clr_i  (clr_i),
                .r_en   (r_en),
                .r_zero (r_oob),
                .r_addr (r_addr),
                .w_en   (w_ok && w_mask[gi]),
                .w_addr (w_addr),
                .w_data (w_data[gi*CH_W +: CH_W]),
                .r_data (r_data[gi*CH_W +: CH_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_reg <= 1'b0;
        end else begin
            r_vld_reg <= r_en;
        end
    end

    assign r_vld = r_vld_reg;

endmodule

// File: tb/tb_cabac_mvd_neigh_buf.sv
module tb_cabac_mvd_neigh_buf;

    localparam int DEP = 4;
    localparam int NC  = 2;
    localparam int DW  = 36;

    logic          clk = 1'b0;
    logic          rst, clr_i, r_en, w_en, r_vld;
    logic [1:0]    r_addr, w_addr, w_mask;
    logic [DW-1:0] w_data, r_data;

    // Reference model: one {x,y} pair per entry and list, plus a valid flag.
    logic [8:0]    mx [DEP][NC];
    logic [8:0]    my [DEP][NC];
    bit            mv [DEP][NC];
    logic [DW-1:0] exp_data_q;

    int n_checks = 0;
    int n_fail   = 0;

    cabac_mvd_neigh_buf dut (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_i),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data),
        .r_vld  (r_vld),
        .w_en   (w_en),
        .w_mask (w_mask),
        .w_addr (w_addr),
        .w_data (w_data)
    );

    always #5 clk = ~clk;

    // Stored form of one component: verbatim, or |v| clipped to 255.
    function automatic logic [8:0] conv(input logic [8:0] v);
`ifdef CABAC_MVD_ABS_SAT_EN
        int s;
        int mag;
        s   = v[8] ? int'(v) - 512 : int'(v);
        mag = (s < 0) ? -s : s;
        if (mag > 255) mag = 255;
        return 9'(mag);
`else
        return v;
`endif
    endfunction

    function automatic logic [DW-1:0] pack2(input logic [8:0] x0, input logic [8:0] y0,
                                            input logic [8:0] x1, input logic [8:0] y1);
        return {y1, x1, y0, x0};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        rst = 0; clr_i = 0; r_en = 0; w_en = 0;
        r_addr = 0; w_addr = 0; w_mask = 0; w_data = '0;
    endtask

    // Apply the current inputs for one clock and check the outputs after it.
    task automatic cycle(input string tag);
        logic [DW-1:0] exp_d;
        logic          exp_v;
        int            ra, wa;
        ra    = int'(r_addr);
        wa    = int'(w_addr);
        exp_v = 1'b0;
        exp_d = exp_data_q;
        if (r_en) begin
            exp_v = 1'b1;
            exp_d = '0;
            if (ra < DEP) begin
                for (int c = 0; c < NC; c++) begin
                    if (w_en && w_mask[c] && wa == ra) begin
                        exp_d[c*18 +: 9]     = conv(w_data[c*18 +: 9]);
                        exp_d[c*18 + 9 +: 9] = conv(w_data[c*18 + 9 +: 9]);
                    end else if (mv[ra][c]) begin
                        exp_d[c*18 +: 9]     = mx[ra][c];
                        exp_d[c*18 + 9 +: 9] = my[ra][c];
                    end
                end
            end
        end
        if (rst) begin
            exp_v = 1'b0;
            exp_d = '0;
            for (int a = 0; a < DEP; a++)
                for (int c = 0; c < NC; c++) mv[a][c] = 0;
        end else begin
            if (clr_i)
                for (int a = 0; a < DEP; a++)
                    for (int c = 0; c < NC; c++) mv[a][c] = 0;
            if (w_en && wa < DEP)
                for (int c = 0; c < NC; c++)
                    if (w_mask[c]) begin
                        mx[wa][c] = conv(w_data[c*18 +: 9]);
                        my[wa][c] = conv(w_data[c*18 + 9 +: 9]);
                        mv[wa][c] = 1;
                    end
        end
        exp_data_q = exp_d;
        @(posedge clk);
        #1;
        $display("%s: rst=%0b clr=%0b rd=%0b@%0d wr=%0b@%0d mask=%b wdata=%h -> r_vld=%0b r_data=%h",
                 tag, rst, clr_i, r_en, ra, w_en, wa, w_mask, w_data, r_vld, r_data);
        check({tag, "_vld"}, DW'(r_vld), DW'(exp_v));
        check({tag, "_data"}, r_data, exp_d);
    endtask

    initial begin
        exp_data_q = '0;
        for (int a = 0; a < DEP; a++)
            for (int c = 0; c < NC; c++) begin
                mx[a][c] = '0; my[a][c] = '0; mv[a][c] = 0;
            end
        idle();

        // Reset state.
        rst = 1;
        cycle("reset");
        idle();

        // Reads of never-written entries return zero.
        for (int a = 0; a < DEP; a++) begin
            r_en = 1; r_addr = 2'(a);
            cycle("rd_empty");
        end
        idle();
        cycle("idle_hold");

        // Masked write of ch0 only, then read it back.
        w_en = 1; w_addr = 2; w_mask = 2'b01;
        w_data = pack2(9'h005, 9'h1FD, 9'h0AA, 9'h055);
        cycle("wr_a2");
        idle();
        r_en = 1; r_addr = 2;
        cycle("rd_a2");
`ifndef CABAC_MVD_ABS_SAT_EN
        check("a2_literal", r_data, {18'h0, 9'h1FD, 9'h005});
`endif
        idle();

        // Same-cycle write and read to the same address: bypass.
        w_en = 1; w_addr = 1; w_mask = 2'b11;
        w_data = pack2(9'd2, 9'd0, 9'h1FF, 9'd7);
        r_en = 1; r_addr = 1;
        cycle("bypass");
`ifndef CABAC_MVD_ABS_SAT_EN
        check("bypass_literal", r_data, {9'd7, 9'h1FF, 9'd0, 9'd2});
`endif
        idle();

        // Fill all entries, then clear with a simultaneous write and read.
        for (int a = 0; a < DEP; a++) begin
            w_en = 1; w_addr = 2'(a); w_mask = 2'b11;
            w_data = {$urandom, $urandom};
            cycle("fill");
        end
        clr_i = 1; w_en = 1; w_addr = 3; w_mask = 2'b10;
        w_data = pack2(9'h0F0, 9'h00F, 9'd1, 9'd1);
        r_en = 1; r_addr = 2;
        cycle("clr_wr");
        idle();
        for (int a = 0; a < DEP; a++) begin
            r_en = 1; r_addr = 2'(a);
            cycle("post_clr");
        end
        check("a3_after_clr", r_data, {9'd1, 9'd1, 18'd0});
        idle();

        // Reset mid-stream with a read pending.
        for (int a = 0; a < DEP; a++) begin
            w_en = 1; w_addr = 2'(a); w_mask = 2'b11;
            w_data = {$urandom, $urandom};
            cycle("refill");
        end
        idle();
        rst = 1; r_en = 1; r_addr = 3;
        cycle("rst_mid");
        idle();
        for (int a = 0; a < DEP; a++) begin
            r_en = 1; r_addr = 2'(a);
            cycle("post_rst");
        end
        idle();

        // Most negative x and a small negative y.
        w_en = 1; w_addr = 0; w_mask = 2'b01;
        w_data = pack2(9'h100, 9'h1F9, 9'd0, 9'd0);
        cycle("wr_neg");
        idle();
        r_en = 1; r_addr = 0;
        cycle("rd_neg");
`ifdef CABAC_MVD_ABS_SAT_EN
        check("neg_literal", r_data, {18'd0, 9'd7, 9'd255});
`else
        check("neg_literal", r_data, {18'd0, 9'h1F9, 9'h100});
`endif
        idle();

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(63) == 0);
            clr_i  = ($urandom_range(15) == 0);
            r_en   = $urandom_range(1) != 0;
            r_addr = 2'($urandom_range(3));
            w_en   = $urandom_range(1) != 0;
            w_addr = 2'($urandom_range(3));
            w_mask = 2'($urandom_range(3));
            w_data = {$urandom, $urandom};
            cycle("rand");
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
